dbchecker_ctrl_master: RTL and testbench

//  AXI-Lite initiator that programs and reads the DBChecker s_axil_ctrl register port. Sits between
//  the on-chip management logic and DBChecker. Turns one-at-a-time commands into AXI-Lite transactions
//  and returns the data and response code. Exactly one transaction is in flight at a time.

---
 rtl/dbchecker_ctrl_master.sv | 168 ++++++++++++++++
 tb/tb_dbchecker_ctrl_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbchecker_ctrl_master.sv
// AXI-Lite initiator for the DBChecker control port: one command in, one AXI-Lite transaction out, one response back.
// Optional hung-slave watchdog enabled by defining DBC_CTRL_TIMEOUT_EN.
module dbchecker_ctrl_master #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter logic [2:0]  PROT           = 3'b000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic [ADDR_WIDTH-1:0]     m_axil_ctrl_awaddr,
    output logic [2:0]                m_axil_ctrl_awprot,
    output logic                      m_axil_ctrl_awvalid,
    input  logic                      m_axil_ctrl_awready,
    output logic [DATA_WIDTH-1:0]     m_axil_ctrl_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axil_ctrl_wstrb,
    output logic                      m_axil_ctrl_wvalid,
    input  logic                      m_axil_ctrl_wready,
    input  logic [1:0]                m_axil_ctrl_bresp,
    input  logic                      m_axil_ctrl_bvalid,
    output logic                      m_axil_ctrl_bready,
    output logic [ADDR_WIDTH-1:0]     m_axil_ctrl_araddr,
    output logic [2:0]                m_axil_ctrl_arprot,
    output logic                      m_axil_ctrl_arvalid,
    input  logic                      m_axil_ctrl_arready,
    input  logic [DATA_WIDTH-1:0]     m_axil_ctrl_rdata,
    input  logic [1:0]                m_axil_ctrl_rresp,
    input  logic                      m_axil_ctrl_rvalid,
    output logic                      m_axil_ctrl_rready
);
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [SW-1:0]         wstrb_q;
    logic [1:0]            resp_q;
    logic                  aw_done, w_done, timeout_q;
    logic                  abort;

`ifdef DBC_CTRL_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // Only IDLE leads into WR/RA, so clearing in IDLE is clearing on entry.
    always_ff @(posedge clock) begin
        if (reset)                   wd_cnt <= '0;
        else if (state == IDLE)      wd_cnt <= '0;
        else if (state != RSP)       wd_cnt <= wd_cnt + 16'd1;
    end

    assign abort = (state inside {WR, WB, RA, RD}) && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx            = state;
        cmd_ready           = 1'b0;
        rsp_valid           = 1'b0;
        m_axil_ctrl_awvalid = 1'b0;
        m_axil_ctrl_wvalid  = 1'b0;
        m_axil_ctrl_bready  = 1'b0;
        m_axil_ctrl_arvalid = 1'b0;
        m_axil_ctrl_rready  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = cmd_write ? WR : RA;
            end
            WR: begin
                m_axil_ctrl_awvalid = !aw_done;
                m_axil_ctrl_wvalid  = !w_done;
                if ((aw_done || m_axil_ctrl_awready) && (w_done || m_axil_ctrl_wready))
                    state_nx = WB;
            end
            WB: begin
                m_axil_ctrl_bready = 1'b1;
                if (m_axil_ctrl_bvalid) state_nx = RSP;
            end
            RA: begin
                m_axil_ctrl_arvalid = 1'b1;
                if (m_axil_ctrl_arready) state_nx = RD;
            end
            RD: begin
                m_axil_ctrl_rready = 1'b1;
                if (m_axil_ctrl_rvalid) state_nx = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Watchdog abort wins over any handshake seen in the same cycle
        if (abort) state_nx = RSP;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    addr_q    <= cmd_addr;
                    wdata_q   <= cmd_wdata;
                    wstrb_q   <= cmd_wstrb;
                    rdata_q   <= '0;
                    resp_q    <= 2'b00;
                    aw_done   <= 1'b0;
                    w_done    <= 1'b0;
                    timeout_q <= 1'b0;
                end
                WR: begin
                    if (m_axil_ctrl_awready) aw_done <= 1'b1;
                    if (m_axil_ctrl_wready)  w_done  <= 1'b1;
                end
                WB: if (m_axil_ctrl_bvalid) resp_q <= m_axil_ctrl_bresp;
                RD: if (m_axil_ctrl_rvalid) begin
                    rdata_q <= m_axil_ctrl_rdata;
                    resp_q  <= m_axil_ctrl_rresp;
                end
                default: ;
            endcase
            if (abort) begin
                rdata_q   <= '0;
                resp_q    <= 2'b10;
                timeout_q <= 1'b1;
            end
        end
    end

    assign m_axil_ctrl_awaddr = addr_q;
    assign m_axil_ctrl_araddr = addr_q;
    assign m_axil_ctrl_awprot = PROT;
    assign m_axil_ctrl_arprot = PROT;
    assign m_axil_ctrl_wdata  = wdata_q;
    assign m_axil_ctrl_wstrb  = wstrb_q;
    assign rsp_rdata          = rdata_q;
    assign rsp_resp           = resp_q;
    // Never set in the default build, so it reduces to a constant 0
    assign rsp_timeout        = timeout_q;

endmodule

// File: tb/tb_dbchecker_ctrl_master.sv
// Bench for dbchecker_ctrl_master: AXI-Lite slave with programmable wait states plus a byte-level register model.
module tb_dbchecker_ctrl_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, araddr, wdata, rdata = '0;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic [1:0]  bresp = '0, rresp = '0;

    always #5 clk = ~clk;

    dbchecker_ctrl_master #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axil_ctrl_awaddr(awaddr), .m_axil_ctrl_awprot(awprot),
        .m_axil_ctrl_awvalid(awvalid), .m_axil_ctrl_awready(awready),
        .m_axil_ctrl_wdata(wdata), .m_axil_ctrl_wstrb(wstrb),
        .m_axil_ctrl_wvalid(wvalid), .m_axil_ctrl_wready(wready),
        .m_axil_ctrl_bresp(bresp), .m_axil_ctrl_bvalid(bvalid), .m_axil_ctrl_bready(bready),
        .m_axil_ctrl_araddr(araddr), .m_axil_ctrl_arprot(arprot),
        .m_axil_ctrl_arvalid(arvalid), .m_axil_ctrl_arready(arready),
        .m_axil_ctrl_rdata(rdata), .m_axil_ctrl_rresp(rresp),
        .m_axil_ctrl_rvalid(rvalid), .m_axil_ctrl_rready(rready)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr, wdata;
        logic [3:0]  strb;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  sresp;
        int          hold;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
        bit          exp_to;
    } vec_t;

    int   n_vec = 0, n_err = 0;
    vec_t cfg;
    int   txn_id = 0;

    // Slave-side observations, written only by the slave process
    int          n_aw, n_w, n_b, n_ar, n_r, hi_aw, hi_w, hi_b, hi_ar, hi_r;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    // Reference register file, byte granular
    logic [7:0]  ref_mem [0:255];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return {ref_mem[a[7:0]+3], ref_mem[a[7:0]+2], ref_mem[a[7:0]+1], ref_mem[a[7:0]]};
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++)
            if (s[i]) ref_mem[a[7:0] + i] = d[8*i +: 8];
    endtask

    function automatic vec_t mk(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input int aw, input int w, input int b,
                                input int ar, input int r, input logic [1:0] sr, input int hold,
                                input logic [31:0] erd, input logic [1:0] ers, input int lat,
                                input bit to);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.strb = s;
        v.aw_d = aw; v.w_d = w; v.b_d = b; v.ar_d = ar; v.r_d = r;
        v.sresp = sr; v.hold = hold;
        v.exp_rdata = erd; v.exp_resp = ers; v.exp_lat = lat; v.exp_to = to;
        return v;
    endfunction

    // AXI-Lite slave: updates at 1 time unit after each rising edge; handshakes are
    // recognised from the valid it saw last cycle and the ready it drove.
    initial begin
        logic [31:0] smem [0:63];
        logic p_aw, p_w, p_b, p_ar, p_r;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [3:0]  p_wstrb;
        bit aw_ok, w_ok, wrote, b_done, ar_ok, r_done;
        int aw_w, w_w, ar_w, bw, rw, seen;
        for (int i = 0; i < 64; i++) smem[i] = '0;
        seen = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
                aw_ok = 0; w_ok = 0; wrote = 0; b_done = 0; ar_ok = 0; r_done = 0;
            end else begin
                if (txn_id != seen) begin
                    seen = txn_id;
                    aw_ok = 0; w_ok = 0; wrote = 0; b_done = 0; ar_ok = 0; r_done = 0;
                    aw_w = 0; w_w = 0; ar_w = 0; bw = 0; rw = 0;
                    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
                    hi_aw = 0; hi_w = 0; hi_b = 0; hi_ar = 0; hi_r = 0;
                    cap_awaddr = 'x; cap_wdata = 'x; cap_wstrb = 'x; cap_araddr = 'x;
                end
                if (p_aw && awready) begin n_aw++; aw_ok = 1; cap_awaddr = p_awaddr; end
                if (p_w && wready)   begin n_w++;  w_ok = 1;  cap_wdata = p_wdata; cap_wstrb = p_wstrb; end
                if (p_b && bvalid)   begin n_b++;  bvalid = 0; b_done = 1; end
                if (p_ar && arready) begin n_ar++; ar_ok = 1; cap_araddr = p_araddr; end
                if (p_r && rvalid)   begin n_r++;  rvalid = 0; r_done = 1; end
                if (aw_ok && w_ok && !wrote) begin
                    for (int i = 0; i < 4; i++)
                        if (cap_wstrb[i]) smem[cap_awaddr[7:2]][8*i +: 8] = cap_wdata[8*i +: 8];
                    wrote = 1;
                end
                awready = 0; wready = 0; arready = 0;
                if (awvalid) begin hi_aw++; if (aw_w >= cfg.aw_d) awready = 1; else aw_w++; end
                if (wvalid)  begin hi_w++;  if (w_w  >= cfg.w_d)  wready  = 1; else w_w++;  end
                if (arvalid) begin hi_ar++; if (ar_w >= cfg.ar_d) arready = 1; else ar_w++; end
                if (bready) hi_b++;
                if (rready) hi_r++;
                if (aw_ok && w_ok && !b_done && !bvalid) begin
                    if (bw >= cfg.b_d) begin bvalid = 1; bresp = cfg.sresp; end else bw++;
                end
                if (ar_ok && !r_done && !rvalid) begin
                    if (rw >= cfg.r_d) begin
                        rvalid = 1; rdata = smem[cap_araddr[7:2]]; rresp = cfg.sresp;
                    end else rw++;
                end
                p_aw = awvalid; p_w = wvalid; p_b = bready; p_ar = arvalid; p_r = rready;
                p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb; p_araddr = araddr;
            end
        end
    end

    task automatic run(input vec_t v);
        int lat;
        bit got;
        logic [31:0] rd0;
        logic [1:0]  rs0;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);
        cfg = v;
        txn_id++;
        cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.strb;
        cmd_valid = 1;
        @(posedge clk);
        #1 cmd_valid = 0;
        lat = 0; got = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            got = rsp_valid;
        end
        check("rsp_seen", got, 1);
        check("latency", lat, v.exp_lat);
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("rsp_resp", rsp_resp, v.exp_resp);
        check("rsp_timeout", rsp_timeout, v.exp_to);
        rd0 = rsp_rdata; rs0 = rsp_resp;
        for (int i = 0; i < v.hold; i++) begin
            cmd_valid = 1; cmd_write = ~v.wr; cmd_addr = v.addr + 32'h40;
            @(negedge clk);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, rd0);
            check("hold_resp", rsp_resp, rs0);
        end
        cmd_valid = 0;
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        @(negedge clk);
        check("post_cmd_ready", cmd_ready, 1);
        check("post_rsp_valid", rsp_valid, 0);
        if (!v.exp_to) begin
            check("n_aw", n_aw, v.wr);
            check("n_w", n_w, v.wr);
            check("n_b", n_b, v.wr);
            check("n_ar", n_ar, !v.wr);
            check("n_r", n_r, !v.wr);
            check("awvalid_cycles", hi_aw, v.wr ? v.aw_d + 1 : 0);
            check("wvalid_cycles", hi_w, v.wr ? v.w_d + 1 : 0);
            check("bready_cycles", hi_b, v.wr ? v.b_d + 1 : 0);
            check("arvalid_cycles", hi_ar, v.wr ? 0 : v.ar_d + 1);
            check("rready_cycles", hi_r, v.wr ? 0 : v.r_d + 1);
            if (v.wr) begin
                check("awaddr", cap_awaddr, v.addr);
                check("wdata", cap_wdata, v.wdata);
                check("wstrb", cap_wstrb, v.strb);
            end else begin
                check("araddr", cap_araddr, v.addr);
            end
        end else begin
            check("to_arvalid_cycles", hi_ar, 16);
            check("to_n_ar", n_ar, 0);
            check("to_n_r", n_r, 0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_valids"}, {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        check({tag, "_rsp"}, {rsp_resp, rsp_timeout}, 0);
        check({tag, "_rdata"}, rsp_rdata, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        vec_t v;
        int   n;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        //         wr addr      wdata         strb aw w  b ar r sresp hold exp_rdata     resp  lat to
        tbl[0] = mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,        2'b00, 3, 0);
        tbl[1] = mk(1, 32'h14, 32'hCAFEF00D, 4'hF, 4, 0, 0, 0, 0, 2'b00, 0, 32'h0,        2'b00, 7, 0);
        tbl[2] = mk(1, 32'h04, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,        2'b00, 3, 0);
        tbl[3] = mk(0, 32'h04, 32'h0,        4'h0, 0, 0, 0, 0, 2, 2'b00, 0, 32'h12345678, 2'b00, 5, 0);
        tbl[4] = mk(1, 32'h18, 32'h11111111, 4'hF, 0, 0, 0, 0, 0, 2'b10, 5, 32'h0,        2'b10, 3, 0);
        tbl[5] = mk(1, 32'h04, 32'hAABBCCDD, 4'h5, 1, 3, 2, 0, 0, 2'b00, 0, 32'h0,        2'b00, 8, 0);
        tbl[6] = mk(0, 32'h04, 32'h0,        4'h0, 0, 0, 0, 2, 1, 2'b00, 0, 32'h12BB56DD, 2'b00, 6, 0);
        tbl[7] = mk(0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b01, 1, 32'hDEADBEEF, 2'b01, 3, 0);
        cfg = tbl[0];

        repeat (3) @(posedge clk);
        #2;
        check_reset_state("reset");
        check("reset_addr", {awaddr | araddr | wdata}, 0);
        check("reset_wstrb", wstrb, 0);
        check("prot", {awprot, arprot}, 0);
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 8; i++) begin
            run(tbl[i]);
            if (tbl[i].wr) model_wr(tbl[i].addr, tbl[i].wdata, tbl[i].strb);
        end

        // Reset while waiting on B
        @(negedge clk);
        v = mk(1, 32'hA0, 32'h0BADF00D, 4'hF, 0, 0, 10, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        cfg = v;
        txn_id++;
        cmd_write = 1; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.strb; cmd_valid = 1;
        @(posedge clk);
        #1 cmd_valid = 0;
        n = 0;
        while (!bready && n < 20) begin @(negedge clk); n++; end
        check("reach_wb", bready, 1);
        reset = 1;
        @(posedge clk);
        #2;
        check_reset_state("reset_in_wb");
        @(negedge clk);
        reset = 0;

`ifdef DBC_CTRL_TIMEOUT_EN
        run(mk(0, 32'h08, 32'h0, 4'h0, 0, 0, 0, 1000, 0, 2'b00, 0, 32'h0, 2'b10, 17, 1));
`endif

        for (int k = 0; k < 40; k++) begin
            v.wr = 1'($urandom_range(0, 1));
            v.addr = 32'($urandom_range(0, 15)) * 4;
            v.wdata = $urandom;
            v.strb = 4'($urandom_range(0, 15));
            v.aw_d = $urandom_range(0, 3); v.w_d = $urandom_range(0, 3); v.b_d = $urandom_range(0, 3);
            v.ar_d = $urandom_range(0, 3); v.r_d = $urandom_range(0, 3);
            v.sresp = 2'($urandom_range(0, 3));
            v.hold = $urandom_range(0, 2);
            v.exp_resp = v.sresp;
            v.exp_to = 0;
            v.exp_rdata = v.wr ? 32'h0 : model_rd(v.addr);
            v.exp_lat = v.wr ? 3 + (v.aw_d > v.w_d ? v.aw_d : v.w_d) + v.b_d : 3 + v.ar_d + v.r_d;
            run(v);
            if (v.wr) model_wr(v.addr, v.wdata, v.strb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
